// File: rtl/axi4_slave_write_responder.sv
// AXI4 slave write responder: AW/W/B handshakes into a byte memory.
// FIXED/INCR bursts, 1/2/4-byte beats, SLVERR on bad bursts or wlast misalignment.
module axi4_slave_write_responder #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 8,
  parameter int LENGTH        = 8,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ID_WIDTH-1:0]      awid,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic [LENGTH-1:0]        awlen,
  input  logic [2:0]               awsize,
  input  logic [1:0]               awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [STROBE_WIDTH-1:0]  wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [ID_WIDTH-1:0]      bid,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDRESS_WIDTH-1:0] dbg_addr,
  output logic [7:0]               dbg_rdata
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int CW    = LENGTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [ID_WIDTH-1:0]      r_id;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [LENGTH-1:0]        r_len;
  logic [2:0]               r_size;
  logic [1:0]               r_burst;
  logic [CW-1:0]            r_cnt;
  logic                     r_err;
  logic [1:0]               r_bresp;
  logic [7:0]               r_mem [DEPTH];

  logic                     w_aw_hs;
  logic                     w_w_hs;
  logic                     w_aw_bad;
  logic [ADDRESS_WIDTH-1:0] w_step;
  logic [ADDRESS_WIDTH-1:0] w_mask;
  logic [ADDRESS_WIDTH-1:0] w_off;
  logic [ADDRESS_WIDTH-1:0] w_beat;
  logic [ADDRESS_WIDTH-1:0] w_line;
  logic [1:0]               w_lo;
  logic [1:0]               w_hi;
  logic                     w_over;
  logic                     w_misfit;
  logic                     w_we;

  assign awready   = (r_state == IDLE);
  assign wready    = (r_state == DATA);
  assign bvalid    = (r_state == RESP);
  assign bid       = r_id;
  assign bresp     = r_bresp;
  assign dbg_rdata = r_mem[dbg_addr];

  assign w_aw_hs  = awvalid & awready;
  assign w_w_hs   = wvalid & wready;
  assign w_aw_bad = awburst[1] | (awsize > 3'd2);

  assign w_step = ADDRESS_WIDTH'(1) << r_size;
  assign w_mask = w_step - ADDRESS_WIDTH'(1);
  assign w_off  = ADDRESS_WIDTH'(r_cnt) << r_size;
  assign w_beat = (r_burst == 2'b01 && r_cnt != '0)
                ? (r_addr & ~w_mask) + w_off
                : r_addr;
  assign w_line = w_beat & ~ADDRESS_WIDTH'(3);
  assign w_lo   = w_beat[1:0];
  assign w_hi   = (w_lo & ~w_mask[1:0]) + w_step[1:0] - 2'd1;

  assign w_over   = r_cnt > {1'b0, r_len};
  assign w_misfit = r_cnt != {1'b0, r_len};
  // r_err here means either a rejected AW or an overrun beat; both discard data
  assign w_we     = w_w_hs & ~r_err & ~w_over;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (awvalid) w_next = DATA;
      DATA:    if (wvalid && wlast) w_next = RESP;
      RESP:    if (bready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_bresp <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_aw_hs) begin
        r_id    <= awid;
        r_addr  <= awaddr;
        r_len   <= awlen;
        r_size  <= awsize;
        r_burst <= awburst;
        r_cnt   <= '0;
        r_err   <= w_aw_bad;
      end
      if (w_w_hs) begin
        if (r_cnt != '1) r_cnt <= r_cnt + CW'(1);
        if (w_over) r_err <= 1'b1;
        if (wlast) r_bresp <= (r_err | w_misfit) ? 2'b10 : 2'b00;
      end
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge aclk) begin
    for (int i = 0; i < STROBE_WIDTH; i++) begin
      if (w_we && wstrb[i] && 2'(i) >= w_lo && 2'(i) <= w_hi)
        r_mem[w_line + ADDRESS_WIDTH'(i)] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Randomized bench for axi4_slave_write_responder.
// Byte-array reference model driven by burst address/lane arithmetic.
module tb_axi4_slave_write_responder;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  awid;
  logic [7:0]  awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  dbg_addr;
  logic [7:0]  dbg_rdata;

  logic [7:0]  ref_mem [256];
  bit          filled;
  int          n_chk;
  int          n_fail;

  always #5 aclk = ~aclk;

  axi4_slave_write_responder dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .awid      (awid),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bid       (bid),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_awready"}, 32'(awready), 1);
    chk({tag, "_wready"}, 32'(wready), 0);
    chk({tag, "_bvalid"}, 32'(bvalid), 0);
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < 256; i++) begin
      dbg_addr = 8'(i);
      #0.1;
      chk({tag, "_mem"}, {24'(i), dbg_rdata}, {24'(i), ref_mem[i]});
    end
  endtask

  // strb < 0 picks a random strobe per beat; abort_at >= 0 resets mid-burst
  task automatic txn(input logic [7:0] id, input int addr, input int len,
                     input int size, input int burst, input int nb,
                     input int strb, input int bdly, input int abort_at);
    bit   bad;
    int   bytes;
    int   a;
    int   lo;
    int   hi;
    int   k;
    logic [1:0] exp_resp;
    bad   = (burst >= 2) || (size > 2);
    bytes = 1 << size;
    exp_resp = (bad || nb != len + 1) ? 2'b10 : 2'b00;
    @(negedge aclk);
    awid = id; awaddr = 8'(addr); awlen = 8'(len);
    awsize = 3'(size); awburst = 2'(burst); awvalid = 1'b1;
    k = 0;
    while (!awready && k < 50) begin @(negedge aclk); k++; end
    chk("aw_timeout", 32'(k < 50), 1);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int n = 0; n < nb; n++) begin
      if (n == abort_at) begin
        aresetn = 1'b0;
        wvalid  = 1'b0;
        #1;
        chk_idle("abort");
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk_idle("abort_rel");
        chk_mem("abort");
        return;
      end
      if (burst == 0 || n == 0 || bad) a = addr;
      else a = ((addr / bytes) * bytes + n * bytes) % 256;
      wdata  = $urandom;
      wstrb  = (strb < 0) ? 4'($urandom) : 4'(strb);
      wlast  = (n == nb - 1);
      wvalid = 1'b1;
      if (filled) begin
        dbg_addr = 8'(a);
        #0.1;
        chk("peek_old", 32'(dbg_rdata), 32'(ref_mem[a]));
      end
      k = 0;
      while (!wready && k < 50) begin @(negedge aclk); k++; end
      chk("w_timeout", 32'(k < 50), 1);
      if (!bad && n <= len) begin
        lo = a % 4;
        hi = (lo / bytes) * bytes + bytes - 1;
        for (int i = 0; i < 4; i++)
          if (wstrb[i] && i >= lo && i <= hi)
            ref_mem[((a / 4) * 4 + i) % 256] = wdata[8*i +: 8];
      end
      @(negedge aclk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    k = 0;
    while (!bvalid && k < 50) begin @(negedge aclk); k++; end
    chk("b_timeout", 32'(k < 50), 1);
    for (int d = 0; d <= bdly; d++) begin
      chk("bvalid", 32'(bvalid), 1);
      chk("bid", 32'(bid), 32'(id));
      chk("bresp", 32'(bresp), 32'(exp_resp));
      chk("awready_resp", 32'(awready), 0);
      if (d < bdly) @(negedge aclk);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk_idle("post_b");
    if (filled) chk_mem("txn");
  endtask

  initial begin
    int len;
    int nb;
    n_chk = 0; n_fail = 0; filled = 0;
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; dbg_addr = '0;
    repeat (3) @(negedge aclk);
    chk_idle("reset");
    chk("reset_bid", 32'(bid), 0);
    chk("reset_bresp", 32'(bresp), 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk_idle("released");
    // define every byte before comparing memory
    txn(8'h01, 0, 63, 2, 1, 64, 15, 0, -1);
    filled = 1;
    chk_mem("fill");
    txn(8'h5A, 8'h10, 3, 2, 1, 4, 15, 0, -1);
    txn(8'h22, 8'h20, 2, 2, 0, 3, 15, 1, -1);
    txn(8'h33, 8'h03, 1, 0, 1, 2, 15, 0, -1);
    txn(8'h44, 8'hFC, 1, 2, 1, 2, 15, 0, -1);
    txn(8'h55, 8'h40, 0, 2, 2, 1, 15, 0, -1);
    txn(8'h66, 8'h50, 3, 2, 1, 2, 15, 0, -1);
    txn(8'h67, 8'h60, 1, 1, 1, 4, 15, 0, -1);
    txn(8'h68, 8'h70, 0, 3, 1, 1, 15, 0, -1);
    txn(8'h77, 8'h80, 1, 2, 1, 2, 15, 5, -1);
    txn(8'h88, 8'h90, 3, 2, 1, 4, 15, 0, 2);
    txn(8'h99, 8'hA1, 2, 1, 1, 3, 15, 0, -1);
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 5);
      case ($urandom_range(0, 5))
        0:       nb = (len > 0) ? len : 1;
        1:       nb = len + 2;
        default: nb = len + 1;
      endcase
      txn(8'($urandom), int'($urandom_range(0, 255)), len,
          ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2)),
          ($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1)),
          nb, -1, int'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nb - 1)) : -1);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
